// File: rtl/joy_dir_filter_pkg.sv
// Shared definitions for the joystick direction conditioner.
//   DIR_*          bit index of each direction inside a 4-bit player slice
//   joy_mode_t     restriction mode selected by the mode input
//   prio_enc       fixed priority encoder, up > down > left > right
//   cancel_opposites  drops both bits of an up+down or left+right pair
//   dir_onehot     4-bit one-hot of a direction index
package joy_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    typedef enum logic [1:0] {
        JM_8WAY   = 2'd0,
        JM_4LAST  = 2'd1,
        JM_4FIRST = 2'd2,
        JM_2H     = 2'd3
    } joy_mode_t;

    function automatic logic [1:0] prio_enc(input logic [3:0] v);
        if (v[DIR_UP])        return 2'(DIR_UP);
        else if (v[DIR_DOWN]) return 2'(DIR_DOWN);
        else if (v[DIR_LEFT]) return 2'(DIR_LEFT);
        else                  return 2'(DIR_RIGHT);
    endfunction

    function automatic logic [3:0] cancel_opposites(input logic [3:0] v);
        logic [3:0] r;
        r = v;
        if (v[DIR_UP] && v[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        if (v[DIR_LEFT] && v[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [3:0] dir_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/joy_dir_filter_if.sv
// Direction bus between the input merge and the filter.
//   ce      sample enable for the debounce counters
//   mode    restriction mode, shared by all players
//   indir   raw directions, player p at [4p+3:4p] = {up, down, left, right}
//   outdir  filtered directions, same packing
//   changed per-player one-cycle pulse when that outdir slice changes
// master drives ce/mode/indir; slave is the filter.
interface joy_dir_filter_if #(
    parameter int PLAYERS = 2
);
    logic                   ce;
    logic [1:0]             mode;
    logic [4*PLAYERS-1:0]   indir;
    logic [4*PLAYERS-1:0]   outdir;
    logic [PLAYERS-1:0]     changed;

    modport master (
        output ce,
        output mode,
        output indir,
        input  outdir,
        input  changed
    );

    modport slave (
        input  ce,
        input  mode,
        input  indir,
        output outdir,
        output changed
    );
endinterface

// File: rtl/joy_dir_filter_debounce.sv
// One direction bit: 2-flop synchroniser followed by an optional debouncer.
//   clk, reset_n  clock, asynchronous active-low reset
//   ce_i          debounce sample enable
//   raw_i         asynchronous raw level
//   level_o       accepted (synchronised, debounced) level
// The accepted level flips only after DB_LEN consecutive ce samples that
// disagree with it; any agreeing sample restarts the count.
module joy_debounce #(
    parameter int DB_EN  = 1,
    parameter int DB_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce_i,
    input  logic raw_i,
    output logic level_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DB_EN != 0) begin : g_db
            localparam logic [7:0] LEN = 8'(DB_LEN);

            logic       lvl_q, lvl_d;
            logic [7:0] cnt_q, cnt_d;

            // The count is cleared on accept, so it stays below DB_LEN and
            // cannot wrap.
            always_comb begin
                lvl_d = lvl_q;
                cnt_d = cnt_q;
                if (ce_i) begin
                    if (sync2_q == lvl_q) begin
                        cnt_d = '0;
                    end else if (cnt_q + 8'd1 == LEN) begin
                        lvl_d = ~lvl_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lvl_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    lvl_q <= lvl_d;
                    cnt_q <= cnt_d;
                end
            end

            assign level_o = lvl_q;
        end else begin : g_bypass
            logic unused_ce;
            assign unused_ce = ce_i;
            assign level_o   = sync2_q;
        end
    endgenerate

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner.
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           joy_dir_filter_if slave: ce, mode, indir in; outdir, changed out
// Each direction bit is synchronised and debounced, then each player slice is
// restricted according to mode: 8-way with opposite-pair cancel, 4-way
// last-pressed-wins, 4-way first-pressed-holds, or 2-way horizontal.
// outdir and changed are registered.
module joy_dir_filter
    import joy_pkg::*;
#(
    parameter int PLAYERS = 2,
    parameter int DB_EN   = 1,
    parameter int DB_LEN  = 8
) (
    input  logic clk,
    input  logic reset_n,
    joy_dir_filter_if.slave bus
);

    localparam int NB = 4 * PLAYERS;

    logic [NB-1:0] acc;
    logic [NB-1:0] acc_prev_q;
    logic [1:0]    mode_prev_q;
    logic          mode_chg;
    joy_mode_t     mode_e;

    assign mode_e   = joy_mode_t'(bus.mode);
    assign mode_chg = (bus.mode != mode_prev_q);

    generate
        for (genvar b = 0; b < NB; b++) begin : g_bit
            joy_debounce #(
                .DB_EN  (DB_EN),
                .DB_LEN (DB_LEN)
            ) u_db (
                .clk     (clk),
                .reset_n (reset_n),
                .ce_i    (bus.ce),
                .raw_i   (bus.indir[b]),
                .level_o (acc[b])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_prev_q  <= '0;
            mode_prev_q <= '0;
        end else begin
            acc_prev_q  <= acc;
            mode_prev_q <= bus.mode;
        end
    end

    generate
        for (genvar p = 0; p < PLAYERS; p++) begin : g_player
            logic [3:0] lvl;
            logic [3:0] rise;
            logic [3:0] held;
            logic [3:0] rose;
            logic [1:0] cur_q, cur_d;
            logic       valid_q, valid_d;
            logic [3:0] out_q, out_d;
            logic       chg_q;

            assign lvl  = acc[4*p +: 4];
            assign rise = lvl & ~acc_prev_q[4*p +: 4];

            // A mode change drops any selection and blanks the slice for one
            // cycle; the next cycle starts from the idle rule of the new mode.
            always_comb begin
                cur_d   = cur_q;
                valid_d = valid_q;
                out_d   = '0;
                held    = lvl;
                rose    = rise;
                if (mode_e == JM_2H) begin
                    held = lvl & 4'b0011;
                    rose = rise & 4'b0011;
                end

                if (mode_chg) begin
                    valid_d = 1'b0;
                end else begin
                    case (mode_e)
                        JM_8WAY: begin
                            valid_d = 1'b0;
                        end
                        JM_4LAST, JM_2H: begin
                            if (|rose) begin
                                cur_d   = prio_enc(rose);
                                valid_d = 1'b1;
                            end else if (!(valid_q && held[cur_q])) begin
                                cur_d   = prio_enc(held);
                                valid_d = |held;
                            end
                        end
                        JM_4FIRST: begin
                            if (!(valid_q && held[cur_q])) begin
                                cur_d   = prio_enc(held);
                                valid_d = |held;
                            end
                        end
                        default: begin
                            valid_d = 1'b0;
                        end
                    endcase

                    if (mode_e == JM_8WAY) begin
                        out_d = cancel_opposites(lvl);
                    end else if (valid_d) begin
                        out_d = dir_onehot(cur_d);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cur_q   <= '0;
                    valid_q <= 1'b0;
                    out_q   <= '0;
                    chg_q   <= 1'b0;
                end else begin
                    cur_q   <= cur_d;
                    valid_q <= valid_d;
                    out_q   <= out_d;
                    chg_q   <= |(out_d ^ out_q);
                end
            end

            assign bus.outdir[4*p +: 4] = out_q;
            assign bus.changed[p]       = chg_q;
        end
    endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: dut0 (no debounce) is checked every cycle against
// a behavioural model plus directed literal checks; dut1 (DB_LEN=8, ce every
// 4 clk) exercises glitch rejection and acceptance latency.
module tb_joy_dir_filter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    joy_dir_filter_if #(.PLAYERS(2)) b0 ();
    joy_dir_filter_if #(.PLAYERS(2)) b1 ();

    joy_dir_filter #(.PLAYERS(2), .DB_EN(0), .DB_LEN(8)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    joy_dir_filter #(.PLAYERS(2), .DB_EN(1), .DB_LEN(8)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference for dut0 ----------------
    // Raw samples seen at the last three rising edges; the filter at edge n
    // acts on the raw level sampled at edge n-2 (two synchroniser stages).
    bit [7:0] hist [3];
    int       m_cur [2];
    bit       m_valid [2];
    bit [3:0] m_out [2];
    bit       m_chg [2];
    bit [1:0] m_mode_prev;

    function automatic int hi_bit(input bit [3:0] v);
        for (int d = 3; d >= 0; d--) if (v[d]) return d;
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            for (int p = 0; p < 2; p++) begin
                m_cur[p] = 0; m_valid[p] = 0; m_out[p] = '0; m_chg[p] = 0;
            end
            m_mode_prev = '0;
        end else begin
            bit [3:0] a, r, nout, lim;
            int md;
            md = int'(b0.mode);
            for (int p = 0; p < 2; p++) begin
                a = hist[1][4*p +: 4];
                r = a & ~hist[2][4*p +: 4];
                nout = '0;
                if (b0.mode != m_mode_prev) begin
                    m_valid[p] = 0;
                end else if (md == 0) begin
                    nout = a;
                    if (a[3] && a[2]) nout[3:2] = 2'b00;
                    if (a[1] && a[0]) nout[1:0] = 2'b00;
                    m_valid[p] = 0;
                end else begin
                    lim = (md == 3) ? 4'b0011 : 4'b1111;
                    a = a & lim;
                    r = r & lim;
                    if (md != 2 && r != 0) begin
                        m_cur[p] = hi_bit(r);
                        m_valid[p] = 1;
                    end else if (!(m_valid[p] && a[m_cur[p]])) begin
                        m_valid[p] = (a != 0);
                        if (a != 0) m_cur[p] = hi_bit(a);
                    end
                    if (m_valid[p]) nout = 4'(1 << m_cur[p]);
                end
                m_chg[p] = (nout != m_out[p]);
                m_out[p] = nout;
            end
            m_mode_prev = b0.mode;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = b0.indir;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_outdir", 32'(b0.outdir), 32'({m_out[1], m_out[0]}));
            check("model_changed", 32'(b0.changed), 32'({m_chg[1], m_chg[0]}));
        end
    end

    // dut1 sample enable: one clk in four
    int ncnt = 0;
    always @(negedge clk) begin
        ncnt++;
        b1.ce = (ncnt % 4 == 0);
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [1:0] mode;
        logic [7:0] stim;
        logic [7:0] exp;
    } row_t;

    row_t tbl [18] = '{
        '{2'd1, 8'h41, 8'h41},  // p0 right, p1 down
        '{2'd1, 8'h49, 8'h48},  // p0 adds up -> up
        '{2'd1, 8'h41, 8'h41},  // p0 releases up -> right
        '{2'd1, 8'h00, 8'h00},
        '{2'd1, 8'h4A, 8'h48},  // p0 up+left together -> up
        '{2'd1, 8'h00, 8'h00},
        '{2'd2, 8'h12, 8'h12},  // p0 left, p1 right
        '{2'd2, 8'h96, 8'h12},  // p0 adds down, p1 adds up: both held
        '{2'd2, 8'h84, 8'h84},  // p0 keeps down, p1 keeps up
        '{2'd2, 8'h00, 8'h00},
        '{2'd0, 8'h39, 8'h09},  // p0 up+right diagonal, p1 left+right cancel
        '{2'd0, 8'hCE, 8'h02},  // p0 up+down+left -> left, p1 up+down -> 0
        '{2'd0, 8'h00, 8'h00},
        '{2'd3, 8'h1C, 8'h10},  // p0 up+down -> 0, p1 right
        '{2'd3, 8'h02, 8'h02},  // p0 left
        '{2'd3, 8'h03, 8'h01},  // p0 adds right -> right
        '{2'd3, 8'h02, 8'h02},  // p0 releases right -> left
        '{2'd3, 8'h00, 8'h00}
    };

    logic [7:0] last_exp = '0;

    task automatic expect_after(input logic [7:0] stim, input logic [7:0] exp, input string name);
        int pulses [2];
        pulses[0] = 0;
        pulses[1] = 0;
        b0.indir = stim;
        repeat (5) begin
            @(negedge clk);
            pulses[0] += int'(b0.changed[0]);
            pulses[1] += int'(b0.changed[1]);
        end
        check({name, "_out"}, 32'(b0.outdir), 32'(exp));
        for (int p = 0; p < 2; p++)
            check($sformatf("%s_pulse%0d", name, p), 32'(pulses[p]),
                  (exp[4*p +: 4] != last_exp[4*p +: 4]) ? 32'd1 : 32'd0);
        last_exp = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int first;
        int pulses;
        int nz;

        b0.ce = 1'b1;
        b0.mode = 2'd0;
        b0.indir = '0;
        b1.mode = 2'd0;
        b1.indir = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outdir0", 32'(b0.outdir), 32'h0);
        check("reset_changed0", 32'(b0.changed), 32'h0);
        check("reset_outdir1", 32'(b1.outdir), 32'h0);
        reset_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].mode != b0.mode) begin
                b0.mode = tbl[i].mode;
                repeat (3) @(negedge clk);
            end
            expect_after(tbl[i].stim, tbl[i].exp, $sformatf("row%0d", i));
        end

        // Mode switch while held: one blank cycle, then the new mode's result.
        b0.mode = 2'd1;
        repeat (3) @(negedge clk);
        expect_after(8'h48, 8'h48, "mc_hold");
        b0.mode = 2'd0;
        @(negedge clk);
        check("mc_zero_out", 32'(b0.outdir), 32'h00);
        check("mc_zero_chg", 32'(b0.changed), 32'h3);
        @(negedge clk);
        check("mc_resume_out", 32'(b0.outdir), 32'h48);
        check("mc_resume_chg", 32'(b0.changed), 32'h3);

        // Asynchronous reset while held.
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_out", 32'(b0.outdir), 32'h0);
        check("rst_mid_chg", 32'(b0.changed), 32'h0);
        b0.indir = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        last_exp = '0;

        // Glitch of exactly 7 ce samples on dut1 player 0 up.
        nz = 0;
        b1.indir = 8'h08;
        for (int k = 0; k < 73; k++) begin
            if (k == 28) b1.indir = '0;
            @(negedge clk);
            if (b1.outdir != '0) nz++;
        end
        check("db_reject_cycles", 32'(nz), 32'd0);

        // Level held for exactly 8 ce samples is accepted.
        first = -1;
        pulses = 0;
        b1.indir = 8'h08;
        for (int k = 1; k <= 60; k++) begin
            if (k == 33) b1.indir = '0;
            @(negedge clk);
            if (first < 0 && b1.outdir[3]) first = k;
            pulses += int'(b1.changed[0]);
        end
        checks++;
        if (!(first >= 32 && first <= 35)) begin
            errors++;
            $display("FAIL db_latency: got %0d clk, required 32..35", first);
        end
        check("db_accept_out", 32'(b1.outdir), 32'h08);
        check("db_accept_pulses", 32'(pulses), 32'd1);
        repeat (45) @(negedge clk);
        check("db_release_out", 32'(b1.outdir), 32'h00);

        // Randomised run on dut0 against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 2000) begin
                @(posedge clk);
                #1 reset_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 79) == 0) b0.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = int'($urandom_range(0, 7));
                b0.indir[idx] = ~b0.indir[idx];
            end
            if ($urandom_range(0, 19) == 0) b0.indir = b0.indir ^ 8'($urandom_range(0, 255));
        end
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
